// File: rtl/i2s_cond_pkg.sv
// rtl/i2s_cond_pkg.sv - shared encodings, defaults and helpers for the I2S sample conditioner
package i2s_cond_pkg;

  typedef enum logic [1:0] {
    CH_LEFT  = 2'b00,
    CH_RIGHT = 2'b01,
    CH_MONO  = 2'b10,
    CH_RSVD  = 2'b11
  } chan_e;

  localparam int SAMPLE_W_DEF = 24;
  localparam int OUT_W_DEF    = 16;

  // Clamp a signed value to the range of a w-bit two's-complement number (w <= 31).
  function automatic logic signed [31:0] sat_to(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [1:0] clamp_decim(input logic [1:0] d, input int dmax);
    if (int'(d) > dmax) return 2'(dmax);
    return d;
  endfunction

endpackage

// File: rtl/i2s_dc_blocker.sv
// rtl/i2s_dc_blocker.sv - first-order DC-blocking high-pass with saturation and bypass
module i2s_dc_blocker
  import i2s_cond_pkg::*;
#(
  parameter int W = SAMPLE_W_DEF,
  parameter int K = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                dc_en,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic signed [W-1:0] out_data
);

  localparam int EW = W + 2;

  logic                valid_q, valid_d;
  logic signed [W-1:0] data_q, data_d;
  logic signed [W-1:0] x_prev_q, x_prev_d;
  logic signed [W-1:0] y_prev_q, y_prev_d;

  logic signed [EW-1:0] xe, xpe, ype, yw;
  logic signed [W-1:0]  y_sat;

  always_comb begin
    xe    = {{2{in_data[W-1]}}, in_data};
    xpe   = {{2{x_prev_q[W-1]}}, x_prev_q};
    ype   = {{2{y_prev_q[W-1]}}, y_prev_q};
    yw    = xe - xpe + ype - (ype >>> K);
    y_sat = W'(sat_to({{(32-EW){yw[EW-1]}}, yw}, W));

    valid_d  = 1'b0;
    data_d   = data_q;
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    if (clr) begin
      x_prev_d = '0;
      y_prev_d = '0;
    end else if (in_valid) begin
      valid_d = 1'b1;
      if (dc_en) begin
        data_d   = y_sat;
        x_prev_d = in_data;
        y_prev_d = y_sat;
      end else begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/i2s_sample_conditioner.sv
// rtl/i2s_sample_conditioner.sv - channel select, DC block, decimate, gain/saturate to PCM
module i2s_sample_conditioner
  import i2s_cond_pkg::*;
#(
  parameter int SAMPLE_W       = SAMPLE_W_DEF,
  parameter int OUT_W          = OUT_W_DEF,
  parameter int DECIM_LOG2_MAX = 3,
  parameter int DC_K           = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_chan,
  input  logic             cfg_dc_en,
  input  logic [1:0]       cfg_decim,
  input  logic [2:0]       cfg_gain,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_ws,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int AW = SAMPLE_W + DECIM_LOG2_MAX;
  localparam int CW = DECIM_LOG2_MAX;

  logic       en_q, en_d;
  logic [1:0] cfg_chan_q, cfg_chan_d;
  logic       cfg_dc_en_q, cfg_dc_en_d;
  logic [1:0] cfg_decim_q, cfg_decim_d;
  logic [2:0] cfg_gain_q, cfg_gain_d;
  logic       rise;
  chan_e      chan_eff;

  logic                       s1_valid_q, s1_valid_d;
  logic signed [SAMPLE_W-1:0] s1_data_q, s1_data_d;
  logic                       pend_q, pend_d;
  logic signed [SAMPLE_W-1:0] pend_l_q, pend_l_d;
  logic signed [SAMPLE_W-1:0] s_in;
  logic signed [SAMPLE_W:0]   mono_sum;

  logic                       s2_valid;
  logic signed [SAMPLE_W-1:0] s2_data;

  logic signed [AW-1:0]       acc_q, acc_d, sum_w, avg;
  logic [CW-1:0]              cnt_q, cnt_d, cnt_max;
  logic signed [SAMPLE_W-1:0] r;
  logic signed [31:0]         r32, g32, v32;
  logic [OUT_W-1:0]           pcm;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             overrun_q, overrun_d;
  logic             ovr_set;
  logic             unused_lsbs;

  assign unused_lsbs = ^in_data[31-SAMPLE_W:0];
  assign s_in        = in_data[31 -: SAMPLE_W];
  assign rise        = cfg_en & ~en_q;
  // Stage 1 may see a word on the very cycle enable rises, so it uses the live selection then.
  assign chan_eff    = chan_e'(rise ? cfg_chan : cfg_chan_q);

  always_comb begin
    en_d        = cfg_en;
    cfg_chan_d  = rise ? cfg_chan  : cfg_chan_q;
    cfg_dc_en_d = rise ? cfg_dc_en : cfg_dc_en_q;
    cfg_decim_d = rise ? clamp_decim(cfg_decim, DECIM_LOG2_MAX) : cfg_decim_q;
    cfg_gain_d  = rise ? cfg_gain  : cfg_gain_q;
  end

  always_comb begin
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    pend_d     = pend_q;
    pend_l_d   = pend_l_q;
    mono_sum   = {s_in[SAMPLE_W-1], s_in} + {pend_l_q[SAMPLE_W-1], pend_l_q};
    if (!cfg_en) begin
      pend_d   = 1'b0;
      pend_l_d = '0;
    end else if (in_valid) begin
      case (chan_eff)
        CH_RIGHT: if (in_ws) begin
          s1_valid_d = 1'b1;
          s1_data_d  = s_in;
        end
        CH_MONO: if (!in_ws) begin
          pend_l_d = s_in;
          pend_d   = 1'b1;
        end else if (pend_q) begin
          s1_valid_d = 1'b1;
          s1_data_d  = mono_sum[SAMPLE_W:1];
          pend_d     = 1'b0;
        end
        default: if (!in_ws) begin
          s1_valid_d = 1'b1;
          s1_data_d  = s_in;
        end
      endcase
    end
  end

  i2s_dc_blocker #(
    .W(SAMPLE_W),
    .K(DC_K)
  ) u_dc (
    .clk      (HCLK),
    .resetn   (HRESETn),
    .clr      (~cfg_en),
    .dc_en    (cfg_dc_en_q),
    .in_valid (s1_valid_q),
    .in_data  (s1_data_q),
    .out_valid(s2_valid),
    .out_data (s2_data)
  );

  always_comb begin
    sum_w   = acc_q + {{DECIM_LOG2_MAX{s2_data[SAMPLE_W-1]}}, s2_data};
    avg     = sum_w >>> cfg_decim_q;
    r       = SAMPLE_W'(avg);
    cnt_max = CW'((32'd1 << cfg_decim_q) - 32'd1);
    r32     = {{(32-SAMPLE_W){r[SAMPLE_W-1]}}, r};
    g32     = r32 <<< cfg_gain_q;
    v32     = g32 >>> (SAMPLE_W - OUT_W);
    pcm     = OUT_W'(sat_to(v32, OUT_W));
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovr_set     = 1'b0;
    if (!cfg_en) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (s2_valid) begin
        if (cnt_q == cnt_max) begin
          acc_d = '0;
          cnt_d = '0;
          // A held, unaccepted result always wins; the newcomer is dropped.
          if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = pcm;
          end else begin
            ovr_set = 1'b1;
          end
        end else begin
          acc_d = sum_w;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    overrun_d = ovr_set | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      en_q        <= 1'b0;
      cfg_chan_q  <= '0;
      cfg_dc_en_q <= 1'b0;
      cfg_decim_q <= '0;
      cfg_gain_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      pend_q      <= 1'b0;
      pend_l_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      en_q        <= en_d;
      cfg_chan_q  <= cfg_chan_d;
      cfg_dc_en_q <= cfg_dc_en_d;
      cfg_decim_q <= cfg_decim_d;
      cfg_gain_q  <= cfg_gain_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      pend_q      <= pend_d;
      pend_l_q    <= pend_l_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_sample_conditioner.sv
// tb/tb_i2s_sample_conditioner.sv - directed self-checking bench for i2s_sample_conditioner
module tb_i2s_sample_conditioner;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cfg_en;
  logic [1:0]  cfg_chan;
  logic        cfg_dc_en;
  logic [1:0]  cfg_decim;
  logic [2:0]  cfg_gain;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ws;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        overrun;
  logic        clr_overrun;

  int checks = 0;
  int errors = 0;

  i2s_sample_conditioner dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .cfg_en     (cfg_en),
    .cfg_chan   (cfg_chan),
    .cfg_dc_en  (cfg_dc_en),
    .cfg_decim  (cfg_decim),
    .cfg_gain   (cfg_gain),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ws      (in_ws),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic configure(input logic [1:0] ch, input logic dc, input logic [1:0] d, input logic [2:0] g);
    tick();
    cfg_en    = 1'b0;
    cfg_chan  = ch;
    cfg_dc_en = dc;
    cfg_decim = d;
    cfg_gain  = g;
    tick();
    cfg_en = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic ws);
    tick();
    in_valid = 1'b1;
    in_data  = d;
    in_ws    = ws;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: out_valid=%b out_data=%h overrun=%b want 0/0000/0", out_valid, out_data, overrun);
    end
    HRESETn = 1'b1;
  endtask

  task automatic test_left_basic();
    configure(2'b00, 1'b0, 2'd0, 3'd0);
    cfg_gain = 3'd7;
    send_word(32'h12345600, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL left_latency_early: out_valid=%b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      errors++;
      $display("FAIL left_basic: out_valid=%b out_data=%h want 1/1234", out_valid, out_data);
    end
    send_word(32'h7F000000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL left_ignores_right cyc%0d: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_gain_sat();
    logic [31:0] words [2];
    logic [2:0]  gains [2];
    logic [15:0] exps  [2];
    words[0] = 32'h12345600; gains[0] = 3'd4; exps[0] = 16'h7FFF;
    words[1] = 32'hFFFFFF00; gains[1] = 3'd0; exps[1] = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      configure(2'b00, 1'b0, 2'd0, gains[i]);
      send_word(words[i], 1'b0);
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exps[i]) begin
        errors++;
        $display("FAIL gain_sat%0d: out_valid=%b out_data=%h want 1/%h", i, out_valid, out_data, exps[i]);
      end
    end
  endtask

  task automatic test_mono();
    configure(2'b10, 1'b0, 2'd0, 3'd0);
    send_word(32'h00100000, 1'b0);
    send_word(32'h00300000, 1'b1);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0020) begin
      errors++;
      $display("FAIL mono_mix: out_valid=%b out_data=%h want 1/0020", out_valid, out_data);
    end
    send_word(32'h00500000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mono_lone_right cyc%0d: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_decim();
    logic [31:0] words [4];
    words[0] = 32'h00010000;
    words[1] = 32'h00020000;
    words[2] = 32'h00030000;
    words[3] = 32'h00060000;
    configure(2'b00, 1'b0, 2'd2, 3'd0);
    for (int i = 0; i < 3; i++) begin
      send_word(words[i], 1'b0);
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL decim_partial%0d: out_valid=%b want 0", i, out_valid);
      end
    end
    send_word(words[3], 1'b0);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0003) begin
      errors++;
      $display("FAIL decim_result: out_valid=%b out_data=%h want 1/0003", out_valid, out_data);
    end
  endtask

  task automatic test_dc_block();
    logic [15:0] exps [4];
    exps[0] = 16'h1000;
    exps[1] = 16'h0F00;
    exps[2] = 16'h0E10;
    exps[3] = 16'h0D2F;
    configure(2'b00, 1'b1, 2'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      send_word(32'h10000000, 1'b0);
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exps[i]) begin
        errors++;
        $display("FAIL dc_block%0d: out_valid=%b out_data=%h want 1/%h", i, out_valid, out_data, exps[i]);
      end
    end
  endtask

  task automatic test_overrun();
    configure(2'b00, 1'b0, 2'd0, 3'd0);
    out_ready = 1'b0;
    send_word(32'h01000000, 1'b0);
    send_word(32'h02000000, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0100 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: out_valid=%b out_data=%h overrun=%b want 1/0100/1", out_valid, out_data, overrun);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b out_valid=%b want 0/1", overrun, out_valid);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_accum();
    configure(2'b00, 1'b0, 2'd2, 3'd0);
    send_word(32'h07000000, 1'b0);
    send_word(32'h07000000, 1'b0);
    tick();
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b overrun=%b want 0/0", out_valid, overrun);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      send_word(32'h00010000, 1'b0);
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_partial%0d: out_valid=%b want 0", i, out_valid);
      end
    end
    send_word(32'h00010000, 1'b0);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
      errors++;
      $display("FAIL post_reset_group: out_valid=%b out_data=%h want 1/0001", out_valid, out_data);
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    cfg_en      = 1'b0;
    cfg_chan    = 2'b00;
    cfg_dc_en   = 1'b0;
    cfg_decim   = 2'd0;
    cfg_gain    = 3'd0;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    in_ws       = 1'b0;
    out_ready   = 1'b1;
    clr_overrun = 1'b0;

    test_reset();
    test_left_basic();
    test_gain_sat();
    test_mono();
    test_decim();
    test_dc_block();
    test_overrun();
    test_reset_mid_accum();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_sample_conditioner.md
Name: i2s_sample_conditioner

Overview:
Conditions raw I2S receiver words before they enter the sample FIFO of the AHB I2S peripheral. It performs these steps in order:
- channel selection or mono mix
- optional DC-blocking high-pass
- boxcar decimation by 2^D
- gain shift with saturation to 16-bit PCM

The result is presented on a valid/ready port to the FIFO write side. A sticky overrun flag reports samples dropped for lack of ready.

Parameters:
SAMPLE_W, 24, signed sample width, MSB-aligned in the 32-bit receiver word (bits [31:32-SAMPLE_W]).
OUT_W, 16, output PCM width.
DECIM_LOG2_MAX, 3, maximum decimation exponent (factor 1..8).
DC_K, 4, DC-blocker pole shift (pole = 1 - 2^-DC_K).

Ports:
HCLK  in  1  clock; single clock domain.
HRESETn  in  1  synchronous active-low reset, sampled on HCLK rising edge.
cfg_en  in  1  block enable.
cfg_chan  in  2  00 left, 01 right, 10 mono mix (L+R)/2, 11 reserved (treated as 00).
cfg_dc_en  in  1  DC blocker enable.
cfg_decim  in  2  decimation exponent D; values >DECIM_LOG2_MAX clamp to max.
cfg_gain  in  3  left shift 0..7 applied before truncation.
in_valid  in  1  one-cycle pulse: receiver word complete.
in_data  in  32  receiver word.
in_ws  in  1  word select of in_data: 0 left, 1 right.
out_valid  out  1  output sample available.
out_ready  in  1  consumer accepts on out_valid & out_ready.
out_data  out  OUT_W  signed PCM sample.
overrun  out  1  sticky: a result was dropped.
clr_overrun  in  1  one-cycle clear of overrun.

Behaviour:
Reset (HRESETn=0 at posedge):
- out_valid=0, out_data=0, overrun=0.
- All pipeline, accumulator, DC state and pending-left registers are cleared.
- Latched cfg is cleared.

Config latch:
- cfg_chan/dc_en/decim/gain are captured on the cycle cfg_en rises (0->1).
- They are ignored while enabled.

cfg_en=0:
- Pipeline valids, accumulator, decimation counter, DC state x_prev/y_prev and pending-left are all zeroed.
- out_valid drops to 0 the next cycle, even if unconsumed.
- overrun is held.

Stage 1, select, registered on in_valid:
- s = signed in_data[31:32-SAMPLE_W].
- Left mode: only words with in_ws=0 are taken. Right mode: only words with in_ws=1.
- Mono mode:
  - A left word stores pending_L and sets pend.
  - A right word with pend set emits (L+R)>>>1, with a (SAMPLE_W+1)-bit sum and floor rounding, and clears pend.
  - A right word without pend is discarded.
  - A left word with pend set overwrites pending_L.

Stage 2, DC blocker, when dc_en:
- y = x - x_prev + y_prev - (y_prev >>> DC_K).
- Computed in SAMPLE_W+2 bits, saturated to SAMPLE_W.
- y_prev stores the saturated value; x_prev stores x.
- The first sample after enable sees x_prev = y_prev = 0.
- When dc_en=0 the stage passes x through with the same 1-cycle register.

Stage 3, decimation:
- Accumulator width SAMPLE_W+DECIM_LOG2_MAX; counter 0..2^D-1.
- When the counter wraps, result = (acc + sample) >>> D, floor rounding; the accumulator reloads to 0.
- D=0 passes every sample.

Stage 4, gain:
- v = (r <<< gain) >>> (SAMPLE_W-OUT_W), arithmetic, computed wide enough for no loss.
- v is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. 0x8000/0x7FFF.
- Gain shares the stage-3 output register.

Output:
- Latency: out_valid is asserted 3 HCLK cycles after the in_valid that completes a group (stage registers 1,2,3).
- The out_valid/out_data holding register holds until accepted.
- On acceptance in the same cycle a new result arrives, the new result loads and out_valid stays 1.
- If a result arrives while out_valid=1 and out_ready=0:
  - the new result is dropped and the held data is unchanged;
  - overrun is set.
- When a set event and clr_overrun occur in the same cycle, the set wins.

in_valid arrives at most once per 2 HCLK cycles (guaranteed by the receiver); there is no input backpressure.

Decomposition:
Shared package i2s_cond_pkg holds:
- channel-select encodings CH_LEFT/CH_RIGHT/CH_MONO;
- the SAMPLE_W/OUT_W defaults;
- a saturation width function.

One sub-module is natural: i2s_dc_blocker (stage 2: state, saturation and bypass). All other stages stay inline.

Test Plan:
1. left, D=0, gain=0, dc off: in_data=0x12345600, ws=0 -> out_data=0x1234 three cycles later; the ws=1 word is ignored.
2. gain=4, same word -> out_data=0x7FFF (saturated); in_data=0xFFFFFF00 at gain=0 -> 0xFFFF.
3. mono: L=0x00100000, then R=0x00300000 -> 0x0020; a lone R with no pending L -> no output.
4. D=2, left: samples 0x000100, 0x000200, 0x000300, 0x000600 (<<8) -> a single out_data=0x0003 after the 4th; no output after the first three.
5. dc on, constant left 0x10000000 (s=0x100000), DC_K=4 -> outputs 0x1000, then 0x0F00, decaying monotonically.
6. out_ready=0 with two results -> out_data holds the first result, overrun=1. Then clr_overrun -> 0. A reset mid-accumulation (HRESETn=0 for 1 cycle) -> out_valid=0, and the next group starts with count 0.
